// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, widths and buffer entry type for the fetch front end.
package fetch_pkg;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {IDLE, BUSY, SQUASH} state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer with flush; push and pop in the same cycle leave the count unchanged.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  entry_t                 i_data,
    output entry_t                 o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    entry_t      r_mem [DEPTH];
    logic [AW:0] r_wr, r_rd;
    logic        w_full;

    assign o_count = r_wr - r_rd;
    assign o_empty = r_wr == r_rd;
    assign w_full  = o_count == (AW+1)'(DEPTH);
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + (AW+1)'(1);
            if (i_pop && !o_empty) r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && w_full));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, requests words from imem and buffers them for decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets on o_fetch_fault.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_req,
    output logic [31:0]        o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [31:0]        i_imem_rdata,
    input  logic               i_redirect_valid,
    input  logic [31:0]        i_redirect_pc,
    output logic               o_inst_valid,
    input  logic               i_inst_ready,
    output logic [INSTR_W-1:0] o_instruction,
    output logic [31:0]        o_inst_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic               o_fetch_fault,
`endif
    output logic [31:0]        o_inst_pc4
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_fetch_pc, r_sq_addr, w_redirect_pc;
    logic        w_push, w_pop, w_empty, w_halt;
    logic [AW:0] w_count, w_cnt_nxt;
    entry_t      w_entry, w_head;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;
    assign w_redirect_pc = i_redirect_pc;
    assign w_halt        = r_fault;
    assign o_fetch_fault = r_fault;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_fault <= 1'b0;
        else if (i_redirect_valid && |i_redirect_pc[1:0]) r_fault <= 1'b1;
    end
`else
    assign w_redirect_pc = i_redirect_pc & ~32'h3;
    assign w_halt        = 1'b0;
`endif

    // Acked data is dropped when a redirect lands in the same cycle.
    assign w_push    = (r_state == BUSY) && i_imem_ack && !i_redirect_valid;
    assign w_pop     = o_inst_valid && i_inst_ready;
    assign w_cnt_nxt = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_entry   = '{pc: r_fetch_pc, instr: i_imem_rdata};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_entry),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_sq_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_redirect_valid) r_fetch_pc <= w_redirect_pc;
            else if (w_push) r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (r_state == BUSY) r_sq_addr <= r_fetch_pc;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = (!i_redirect_valid && !w_halt && w_count < DEPTH_C) ? BUSY : IDLE;
            BUSY:    w_state_nxt = i_imem_ack ? ((!i_redirect_valid && w_cnt_nxt < DEPTH_C) ? BUSY : IDLE)
                                              : (i_redirect_valid ? SQUASH : BUSY);
            SQUASH:  w_state_nxt = i_imem_ack ? IDLE : SQUASH;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_imem_req  = r_state != IDLE;
        o_imem_addr = (r_state == BUSY) ? r_fetch_pc : (r_state == SQUASH) ? r_sq_addr : '0;
    end

    assign o_inst_valid  = !w_empty;
    assign o_instruction = w_empty ? '0 : w_head.instr;
    assign o_inst_pc     = w_empty ? '0 : w_head.pc;
    assign o_inst_pc4    = w_empty ? '0 : w_head.pc + PC_STEP;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic checked against an in-order stream model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req, ack, redir, ready, valid, late_ack;
    logic [31:0] addr, rdata, redir_pc, instr, ipc, ipc4;
    int          lat, wcnt, tests, fails;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h2002_0005;
    endfunction

    // Memory model: acks once the request has waited lat cycles; late_ack forces a stray ack.
    assign ack   = (req && wcnt >= lat) || late_ack;
    assign rdata = mem_word(addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else wcnt <= (req && !ack) ? wcnt + 1 : 0;
    end

    instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req       (req),
        .o_imem_addr      (addr),
        .i_imem_ack       (ack),
        .i_imem_rdata     (rdata),
        .i_redirect_valid (redir),
        .i_redirect_pc    (redir_pc),
        .o_inst_valid     (valid),
        .i_inst_ready     (ready),
        .o_instruction    (instr),
        .o_inst_pc        (ipc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .o_fetch_fault    (fault),
`endif
        .o_inst_pc4       (ipc4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redir = 1'b0;
        late_ack = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n, xfers;
        logic        saw, prev_stall, prev_hold;
        logic [31:0] exp_pc, prev_addr, prev_pc, prev_instr;
        tests = 0; fails = 0;
        ready = 1'b1; redir = 1'b0; redir_pc = '0; lat = 0; late_ack = 1'b0;
        #12;
        check("rst_req", req, 0);
        check("rst_addr", addr, 0);
        check("rst_valid", valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", ipc, 0);
        check("rst_pc4", ipc4, 0);
        // 1: zero-wait memory, first request and full-rate streaming
        @(posedge clk); #2; rst_n = 1'b1;
        cyc();
        check("t1_req", req, 1);
        check("t1_addr0", addr, 0);
        cyc();
        check("t1_valid", valid, 1);
        check("t1_instr", instr, 32'h2002_0005);
        check("t1_pc", ipc, 0);
        check("t1_pc4", ipc4, 4);
        check("t1_addr4", addr, 4);
        for (int k = 1; k < 7; k++) begin
            cyc();
            check("t1_stream_pc", ipc, 32'(4 * k));
        end
        // 2: decode stalled, buffer fills, requests stop
        ready = 1'b0; lat = 0;
        do_reset();
        cyc(); cyc();
        check("t2_valid", valid, 1);
        check("t2_pc0", ipc, 0);
        cyc();
        check("t2_req_off", req, 0);
        check("t2_hold_pc0", ipc, 0);
        cyc();
        check("t2_req_off2", req, 0);
        check("t2_hold_pc0b", ipc, 0);
        ready = 1'b1;
        cyc();
        check("t2_pc4", ipc, 4);
        check("t2_instr4", instr, mem_word(4));
        // 3: redirect while an address-8 fetch is outstanding
        ready = 1'b1; lat = 3;
        do_reset();
        n = 0;
        while (!(req && addr == 32'h8) && n < 60) begin cyc(); n++; end
        check("t3_reach_addr8", addr, 8);
        redir = 1'b1; redir_pc = 32'h40;
        cyc();
        redir = 1'b0;
        check("t3_squash_req", req, 1);
        check("t3_squash_addr", addr, 8);
        check("t3_flushed", valid, 0);
        n = 0; saw = 1'b0;
        while (!(req && addr != 32'h8) && n < 40) begin saw |= valid; cyc(); n++; end
        check("t3_no_valid", saw, 0);
        check("t3_next_addr", addr, 32'h40);
        n = 0;
        while (!valid && n < 40) begin cyc(); n++; end
        check("t3_first_pc", ipc, 32'h40);
        check("t3_first_instr", instr, mem_word(32'h40));
        // 4: pop and redirect in the same cycle
        ready = 1'b0; lat = 0;
        do_reset();
        cyc(); cyc(); cyc();
        check("t4_head_valid", valid, 1);
        check("t4_head_pc", ipc, 0);
        ready = 1'b1; redir = 1'b1; redir_pc = 32'h100;
        cyc();
        redir = 1'b0;
        check("t4_valid_off", valid, 0);
        n = 0;
        while (!req && n < 20) begin cyc(); n++; end
        check("t4_next_addr", addr, 32'h100);
        // 5: asynchronous reset mid-fetch, stray ack after release
        ready = 1'b0; lat = 3;
        do_reset();
        n = 0;
        while (!valid && n < 20) begin cyc(); n++; end
        check("t5_pre_req", req, 1);
        check("t5_pre_valid", valid, 1);
        rst_n = 1'b0;
        #1;
        check("t5_async_req", req, 0);
        check("t5_async_valid", valid, 0);
        check("t5_async_instr", instr, 0);
        check("t5_async_addr", addr, 0);
        cyc();
        late_ack = 1'b1;
        rst_n = 1'b1;
        cyc();
        late_ack = 1'b0;
        #1;
        check("t5_late_ignored", valid, 0);
        check("t5_req", req, 1);
        check("t5_reset_pc", addr, 0);
        // 6: misaligned redirect target
        ready = 1'b1; lat = 0;
        do_reset();
        cyc(); cyc(); cyc();
        redir = 1'b1; redir_pc = 32'h42;
        cyc();
        redir = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t6_fault", fault, 1);
        n = 0;
        for (int k = 0; k < 20; k++) begin n += int'(req); cyc(); end
        check("t6_no_req", n, 0);
        check("t6_no_valid", valid, 0);
`else
        n = 0;
        while (!req && n < 20) begin cyc(); n++; end
        check("t6_aligned_addr", addr, 32'h40);
        n = 0;
        while (!valid && n < 20) begin cyc(); n++; end
        check("t6_pc", ipc, 32'h40);
        check("t6_instr", instr, mem_word(32'h40));
`endif
        // Randomized traffic against the in-order stream model
        do_reset();
        exp_pc = 32'h0; xfers = 0;
        prev_stall = 1'b0; prev_hold = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_instr = '0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_hold) begin
                check("rnd_req_hold", req, 1);
                check("rnd_addr_hold", addr, prev_addr);
            end
            if (prev_stall) begin
                check("rnd_stall_valid", valid, 1);
                check("rnd_stall_pc", ipc, prev_pc);
                check("rnd_stall_instr", instr, prev_instr);
            end
            ready = $urandom_range(0, 3) != 0;
            lat = $urandom_range(0, 3);
            redir = (c == 1500) || (($urandom_range(0, 15) == 0) && (c < 1500 || c > 1530));
            redir_pc = (c == 1500) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
            #1;
            if (valid && ready) begin
                check("rnd_pc", ipc, exp_pc);
                check("rnd_instr", instr, mem_word(exp_pc));
                check("rnd_pc4", ipc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                xfers++;
            end
            if (redir) exp_pc = redir_pc;
            prev_stall = valid && !ready && !redir;
            prev_hold  = req && !ack;
            prev_addr  = addr;
            prev_pc    = ipc;
            prev_instr = instr;
            cyc();
        end
        redir = 1'b0;
        check("rnd_liveness", xfers > 300, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
